// File: rtl/noc_pkg.sv
// Shared NoC definitions for the MNA and SNA network adapters: flit encoding,
// flit width and the on/off flow-control codes.
package noc_pkg;

   localparam int FLIT_W = 34;

   localparam logic [7:0] ON  = 8'hFF;
   localparam logic [7:0] OFF = 8'h00;

   typedef enum logic [1:0] {
      FLIT_IDLE   = 2'b00,
      FLIT_HEADER = 2'b01,
      FLIT_BODY   = 2'b10,
      FLIT_TAIL   = 2'b11
   } flit_type_e;

   function automatic logic [7:0] on_off(input logic ready);
      return ready ? ON : OFF;
   endfunction

endpackage

// File: rtl/sna_flit_decode.sv
// Splits an incoming NoC flit into its type field and 32-bit payload.
module sna_flit_decode
   import noc_pkg::*;
(
   input  logic [FLIT_W-1:0] noc_data,
   output flit_type_e        flit_type,
   output logic [31:0]       payload
);

   assign flit_type = flit_type_e'(noc_data[FLIT_W-1:FLIT_W-2]);
   assign payload   = noc_data[31:0];

endmodule

// File: rtl/sna_request.sv
// Slave-side NoC adapter: assembles header/body/tail request packets and
// issues them as AXI4-Lite write (AW+W) or read (AR) address transactions.
module sna_request
   import noc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLIT_W-1:0] noc_data,
   input  logic              is_valid,
   output logic [7:0]        is_on_off,
   output logic [31:0]       awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   output logic [31:0]       araddr,
   output logic              arvalid,
   input  logic              arready,
   output logic              req_done,
   output logic              req_write,
   output logic              flit_err
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      BODY = 3'd2,
      WR   = 3'd3,
      RD   = 3'd4
   } state_e;

   state_e      state_r, state_s;
   flit_type_e  flit_type_s;
   logic [31:0] payload_s;
   logic        accept_s;

   logic [31:0] addr_r, addr_s;
   logic [31:0] wdata_r, wdata_s;
   logic [3:0]  wstrb_r, wstrb_s;
   logic        awvalid_r, awvalid_s;
   logic        wvalid_r, wvalid_s;
   logic        arvalid_r, arvalid_s;
   logic        req_done_r, req_done_s;
   logic        req_write_r, req_write_s;
   logic        flit_err_r, flit_err_s;
   logic [7:0]  on_off_r, on_off_s;

   sna_flit_decode u_decode (
      .noc_data  (noc_data),
      .flit_type (flit_type_s),
      .payload   (payload_s)
   );

   // The registered on/off code gates acceptance, so the entry cycle of WR/RD ignores flits.
   assign accept_s = is_valid & (on_off_r == ON);

   // Next-state and next-output computation for the packet FSM.
   always_comb begin
      state_s     = state_r;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      wstrb_s     = wstrb_r;
      awvalid_s   = awvalid_r;
      wvalid_s    = wvalid_r;
      arvalid_s   = arvalid_r;
      req_done_s  = 1'b0;
      req_write_s = req_write_r;
      flit_err_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               case (flit_type_s)
                  FLIT_HEADER: begin
                     addr_s  = payload_s;
                     state_s = HDR;
                  end
                  FLIT_BODY, FLIT_TAIL: flit_err_s = 1'b1;
                  default:              state_s    = IDLE;
               endcase
            end else begin
               state_s = IDLE;
            end
         end
         HDR: begin
            if (accept_s) begin
               case (flit_type_s)
                  FLIT_HEADER: begin
                     addr_s     = payload_s;
                     flit_err_s = 1'b1;
                  end
                  FLIT_BODY: begin
                     wdata_s = payload_s;
                     state_s = BODY;
                  end
                  FLIT_TAIL: begin
                     arvalid_s = 1'b1;
                     state_s   = RD;
                  end
                  default: state_s = HDR;
               endcase
            end else begin
               state_s = HDR;
            end
         end
         BODY: begin
            if (accept_s) begin
               case (flit_type_s)
                  FLIT_HEADER: begin
                     addr_s     = payload_s;
                     flit_err_s = 1'b1;
                     state_s    = HDR;
                  end
                  FLIT_BODY: begin
                     wdata_s    = payload_s;
                     flit_err_s = 1'b1;
                  end
                  FLIT_TAIL: begin
                     wstrb_s   = payload_s[3:0];
                     awvalid_s = 1'b1;
                     wvalid_s  = 1'b1;
                     state_s   = WR;
                  end
                  default: state_s = BODY;
               endcase
            end else begin
               state_s = BODY;
            end
         end
         WR: begin
            // AW and W retire independently; leave only when both are gone.
            if (awvalid_r && awready) begin
               awvalid_s = 1'b0;
            end else begin
               awvalid_s = awvalid_r;
            end
            if (wvalid_r && wready) begin
               wvalid_s = 1'b0;
            end else begin
               wvalid_s = wvalid_r;
            end
            if (!awvalid_s && !wvalid_s) begin
               req_done_s  = 1'b1;
               req_write_s = 1'b1;
               state_s     = IDLE;
            end else begin
               state_s = WR;
            end
         end
         RD: begin
            if (arvalid_r && arready) begin
               arvalid_s   = 1'b0;
               req_done_s  = 1'b1;
               req_write_s = 1'b0;
               state_s     = IDLE;
            end else begin
               state_s = RD;
            end
         end
         default: begin
            state_s   = IDLE;
            awvalid_s = 1'b0;
            wvalid_s  = 1'b0;
            arvalid_s = 1'b0;
         end
      endcase
      on_off_s = on_off(!((state_s == WR) || (state_s == RD)));
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Registered datapath and AXI/NoC outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r      <= 32'h0000_0000;
         wdata_r     <= 32'h0000_0000;
         wstrb_r     <= 4'h0;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         req_done_r  <= 1'b0;
         req_write_r <= 1'b0;
         flit_err_r  <= 1'b0;
         on_off_r    <= OFF;
      end else begin
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         wstrb_r     <= wstrb_s;
         awvalid_r   <= awvalid_s;
         wvalid_r    <= wvalid_s;
         arvalid_r   <= arvalid_s;
         req_done_r  <= req_done_s;
         req_write_r <= req_write_s;
         flit_err_r  <= flit_err_s;
         on_off_r    <= on_off_s;
      end
   end

   assign is_on_off = on_off_r;
   assign awaddr    = addr_r;
   assign araddr    = addr_r;
   assign awvalid   = awvalid_r;
   assign wdata     = wdata_r;
   assign wstrb     = wstrb_r;
   assign wvalid    = wvalid_r;
   assign arvalid   = arvalid_r;
   assign req_done  = req_done_r;
   assign req_write = req_write_r;
   assign flit_err  = flit_err_r;

endmodule
